// File: rtl/mem_access_l3.sv
// mem_access_l3: L3 data-memory access unit; req/ack handshake, stall, load extension, timeout.
// Ports: clk/rstn (async active-low); clear_l3 flush; ins_*_l3 load/store decode; alu_q_l3 address;
//        rs2_q_l3 store data; rd_l3 load dest; mem_* data-memory handshake; stall_l3 pipeline hold;
//        load_valid/rd/data_l3 writeback to L4; misalign_l3 flag; bus_err_l3 timeout pulse.
module mem_access_l3 #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear_l3,
  input  logic        ins_lb_l3,
  input  logic        ins_lh_l3,
  input  logic        ins_lw_l3,
  input  logic        ins_sb_l3,
  input  logic        ins_sh_l3,
  input  logic        ins_sw_l3,
  input  logic [31:0] alu_q_l3,
  input  logic [31:0] rs2_q_l3,
  input  logic [4:0]  rd_l3,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_l3,
  output logic        load_valid_l3,
  output logic [4:0]  load_rd_l3,
  output logic [31:0] load_data_l3,
  output logic        misalign_l3,
  output logic        bus_err_l3
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic is_lw, is_lh, is_lb, is_sw, is_sh, is_sb;
  logic is_load, access, misaligned, start, drop_q, drop_now, ld_q, timeout;
  logic [1:0] size, size_q, off_q;
  logic [3:0] be;
  logic [31:0] wdata, shifted, ext;
  logic [CNT_W-1:0] cnt;
  // one-hot decode with lw>lh>lb>sw>sh>sb priority for illegal multi-hot inputs
  assign is_lw = ins_lw_l3;
  assign is_lh = ins_lh_l3 & !is_lw;
  assign is_lb = ins_lb_l3 & !is_lw & !is_lh;
  assign is_load = is_lw | is_lh | is_lb;
  assign is_sw = ins_sw_l3 & !is_load;
  assign is_sh = ins_sh_l3 & !is_load & !is_sw;
  assign is_sb = ins_sb_l3 & !is_load & !is_sw & !is_sh;
  assign access = is_load | is_sw | is_sh | is_sb;
  // size: 0 byte, 1 half, 2 word
  assign size = (is_lw | is_sw) ? 2'd2 : (is_lh | is_sh) ? 2'd1 : 2'd0;
  assign misaligned = (size == 2'd1 & alu_q_l3[0]) | (size == 2'd2 & alu_q_l3[1:0] != 2'b00);
  assign misalign_l3 = access & misaligned & state == IDLE & !clear_l3;
  assign start = access & !misaligned & state == IDLE & !clear_l3;
  assign be = size == 2'd2 ? 4'b1111 : size == 2'd1 ? 4'b0011 << {alu_q_l3[1], 1'b0} : 4'b0001 << alu_q_l3[1:0];
  assign wdata = size == 2'd2 ? rs2_q_l3 : size == 2'd1 ? {2{rs2_q_l3[15:0]}} : {4{rs2_q_l3[7:0]}};
  // halfword offsets are 0 or 2 when aligned, so one byte-granular shift serves both sizes
  assign shifted = mem_rdata >> {off_q, 3'b000};
  assign ext = size_q == 2'd2 ? mem_rdata : size_q == 2'd1 ? {{16{shifted[15]}}, shifted[15:0]} : {{24{shifted[7]}}, shifted[7:0]};
  assign drop_now = drop_q | clear_l3;
  assign timeout = TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1);
  always_comb begin
    state_nx = state;
    stall_l3 = 1'b0;
    mem_req = 1'b0;
    bus_err_l3 = 1'b0;
    load_valid_l3 = 1'b0;
    case (state)
      IDLE: begin
        stall_l3 = start;
        state_nx = start ? REQ : IDLE;
      end
      REQ: begin
        mem_req = 1'b1;
        stall_l3 = 1'b1;
        bus_err_l3 = !mem_ack & timeout;
        state_nx = mem_ack ? (drop_now ? IDLE : DONE) : timeout ? IDLE : REQ;
      end
      DONE: begin
        load_valid_l3 = ld_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_be <= '0;
      mem_wdata <= '0;
      load_rd_l3 <= '0;
      load_data_l3 <= '0;
      cnt <= '0;
      drop_q <= 1'b0;
      ld_q <= 1'b0;
      size_q <= '0;
      off_q <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        mem_addr <= {alu_q_l3[31:2], 2'b00};
        mem_we <= !is_load;
        mem_be <= be;
        mem_wdata <= wdata;
        load_rd_l3 <= rd_l3;
        ld_q <= is_load;
        size_q <= size;
        off_q <= alu_q_l3[1:0];
        cnt <= '0;
        drop_q <= 1'b0;
      end
      if (state == REQ) begin
        cnt <= cnt + 1'b1;
        drop_q <= drop_now;
        if (mem_ack) load_data_l3 <= ext;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_l3.sv
// tb_mem_access_l3: randomized self-checking bench for mem_access_l3 against a transaction-level model.
module tb_mem_access_l3;
  localparam int TO = 4;
  logic clk = 0, rstn = 0, clear_l3 = 0, mem_ack = 0;
  logic [5:0] ins = '0;
  logic [31:0] alu_q = '0, rs2_q = '0, mem_rdata = '0;
  logic [4:0] rd = '0;
  logic mem_req, mem_we, stall_l3, load_valid_l3, misalign_l3, bus_err_l3;
  logic [31:0] mem_addr, mem_wdata, load_data_l3;
  logic [3:0] mem_be;
  logic [4:0] load_rd_l3;
  int n_tests = 0, n_fail = 0;
  mem_access_l3 #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .clear_l3(clear_l3),
    .ins_lb_l3(ins[0]), .ins_lh_l3(ins[1]), .ins_lw_l3(ins[2]),
    .ins_sb_l3(ins[3]), .ins_sh_l3(ins[4]), .ins_sw_l3(ins[5]),
    .alu_q_l3(alu_q), .rs2_q_l3(rs2_q), .rd_l3(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_l3(stall_l3), .load_valid_l3(load_valid_l3), .load_rd_l3(load_rd_l3),
    .load_data_l3(load_data_l3), .misalign_l3(misalign_l3), .bus_err_l3(bus_err_l3)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // kind: 0 lb, 1 lh, 2 lw, 3 sb, 4 sh, 5 sw; w: wait cycles before ack (-1 = never);
  // clr: cycle of clear_l3 (-1 none, 0 during detect, k>=1 during k-th REQ cycle)
  task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rdata, input int w, input int clr);
    bit ld, mis, dropped;
    int n, lane;
    logic [3:0] be;
    logic [31:0] wd, ld_exp, mask;
    logic [4:0] r;
    ld = kind < 3;
    n = 1 << (kind % 3);
    mis = (int'(addr[1:0]) % n) != 0;
    lane = int'(addr[1:0]) & ~(n - 1);
    be = 4'(((1 << n) - 1) << lane);
    for (int i = 0; i < 4; i++) wd[8*i +: 8] = rs2[8*(i % n) +: 8];
    ld_exp = rdata >> (8 * lane);
    if (n < 4) begin
      mask = (32'd1 << (8 * n)) - 1;
      ld_exp = ld_exp & mask;
      if (ld_exp[8*n-1]) ld_exp = ld_exp | ~mask;
    end
    r = 5'($urandom);
    ins = 6'b1 << kind; alu_q = addr; rs2_q = rs2; rd = r;
    clear_l3 = (clr == 0); mem_ack = 0; mem_rdata = $urandom;
    @(negedge clk);
    chk("misalign", 32'(misalign_l3), 32'(mis && clr != 0));
    chk("stall_detect", 32'(stall_l3), 32'(!mis && clr != 0));
    chk("req_detect", 32'(mem_req), 0);
    @(posedge clk); #1;
    if (mis || clr == 0) begin
      ins = '0; clear_l3 = 0;
      @(negedge clk);
      chk("req_noissue", 32'(mem_req), 0);
      chk("stall_noissue", 32'(stall_l3), 0);
      @(posedge clk); #1;
      return;
    end
    for (int c = 1; c < 64; c++) begin
      mem_ack = (c == w + 1); clear_l3 = (c == clr);
      mem_rdata = (c == w + 1) ? rdata : $urandom;
      @(negedge clk);
      chk("req", 32'(mem_req), 1);
      chk("stall_req", 32'(stall_l3), 1);
      chk("addr", mem_addr, {addr[31:2], 2'b00});
      chk("be", 32'(mem_be), 32'(be));
      chk("we", 32'(mem_we), 32'(!ld));
      if (!ld) chk("wdata", mem_wdata, wd);
      chk("bus_err", 32'(bus_err_l3), 32'(w < 0 && c == TO));
      @(posedge clk); #1;
      if (c == w + 1 || (w < 0 && c == TO)) break;
      if (c == 63) chk("req_bound", 0, 1);
    end
    dropped = w < 0 || (clr >= 1 && clr <= w + 1);
    mem_ack = 0; clear_l3 = 0;
    if (dropped) ins = '0;
    @(negedge clk);
    chk("stall_done", 32'(stall_l3), 0);
    chk("req_done", 32'(mem_req), 0);
    chk("bus_err_done", 32'(bus_err_l3), 0);
    chk("load_valid", 32'(load_valid_l3), 32'(ld && !dropped));
    if (ld && !dropped) begin
      chk("load_data", load_data_l3, ld_exp);
      chk("load_rd", 32'(load_rd_l3), 32'(r));
    end
    @(posedge clk); #1;
    ins = '0; mem_ack = 1'($urandom);
    @(negedge clk);
    chk("lv_after", 32'(load_valid_l3), 0);
    chk("stall_after", 32'(stall_l3), 0);
    chk("req_after", 32'(mem_req), 0);
    @(posedge clk); #1;
    mem_ack = 0;
  endtask
  initial begin
    int kind, n, w, clr, sel;
    logic [31:0] addr;
    @(negedge clk);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_lv", 32'(load_valid_l3), 0);
    chk("rst_ld", load_data_l3, 0);
    chk("rst_stall", 32'(stall_l3), 0);
    rstn = 1;
    @(posedge clk); #1;
    run_op(0, 32'h1003, 32'h0, 32'h80FF1234, 0, -1);
    run_op(4, 32'h2002, 32'hDEADBEEF, 32'h0, 0, -1);
    run_op(2, 32'h3000, 32'h0, 32'hCAFEF00D, 3, -1);
    run_op(2, 32'h3002, 32'h0, 32'h0, 0, -1);
    run_op(1, 32'h4002, 32'h0, 32'h8001ABCD, 3, 2);
    run_op(5, 32'h5004, 32'h12345678, 32'h0, -1, -1);
    run_op(3, 32'h6001, 32'hA5A5A5C3, 32'h0, 1, 0);
    run_op(1, 32'h7002, 32'h0, 32'h7FFF8000, 1, -1);
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 5);
      n = 1 << (kind % 3);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'(n - 1);
      w = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      clr = sel == 0 ? 0 : sel == 1 ? int'($urandom_range(1, w < 0 ? TO : w + 1)) : -1;
      run_op(kind, addr, $urandom, $urandom, w, clr);
    end
    ins = 6'b000100; alu_q = 32'h40; rd = 5'd7; clear_l3 = 0; mem_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("req_pre_rst", 32'(mem_req), 1);
    #1 rstn = 0; ins = '0;
    #1;
    chk("arst_req", 32'(mem_req), 0);
    chk("arst_stall", 32'(stall_l3), 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_be", 32'(mem_be), 0);
    chk("arst_we", 32'(mem_we), 0);
    chk("arst_ld", load_data_l3, 0);
    chk("arst_rd", 32'(load_rd_l3), 0);
    @(negedge clk);
    rstn = 1;
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_access_l3.md
Name: mem_access_l3

Overview:
- Stage-3 memory access unit of the 5-stage RISC-V core.
- Consumes the L3 pipeline outputs: the ALU result is the effective address, and rd plus the load/store decode drive the access.
- Runs a req/ack handshake with data memory and holds the pipeline with stall_l3 until the access completes.
- For loads, returns sign-extended data and writeback info to the L4 stage.

Parameters:
- TIMEOUT, 255: max cycles in REQ waiting for mem_ack before abort; 0 disables the timeout.
- CNT_W, 8: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- clear_l3  in  1  flush of the instruction currently in L3.
- ins_lb_l3  in  1  load byte, signed.
- ins_lh_l3  in  1  load halfword, signed.
- ins_lw_l3  in  1  load word.
- ins_sb_l3  in  1  store byte.
- ins_sh_l3  in  1  store halfword.
- ins_sw_l3  in  1  store word.
- alu_q_l3  in  32  effective address.
- rs2_q_l3  in  32  store data.
- rd_l3  in  5  load destination register.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  completes the request.
- stall_l3  out  1  hold request, drives block_l3 and all earlier stages.
- load_valid_l3  out  1  one-cycle pulse: load result valid.
- load_rd_l3  out  5  destination register of the completed load.
- load_data_l3  out  32  extended load data.
- misalign_l3  out  1  misaligned access flagged (combinational).
- bus_err_l3  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: asynchronous, active low, as stated in Ports.
  - Reset values: state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, load_valid_l3, load_rd_l3, load_data_l3, bus_err_l3 and the counter all 0.
  - Reset mid-REQ drops mem_req immediately; the memory side must tolerate this.
- Definitions:
  - access = any ins_*_l3 asserted.
  - misaligned = (lh|sh)&addr[0] | (lw|sw)&(addr[1:0]!=0).
  - misalign_l3 = access & misaligned & state==IDLE & !clear_l3. A misaligned access issues no request and no stall; the instruction passes through.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If access & !clear_l3 & !misaligned: stall_l3=1 combinationally.
  - On the clock edge, register addr, we, be, wdata and rd, plus load size and byte offset; counter=0; go to REQ.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata stay stable until ack.
  - stall_l3=1; counter increments each cycle.
  - mem_ack: capture the extended rdata into load_data_l3, then go to DONE.
  - If clear_l3 was seen in REQ, a sticky drop flag is set. On ack, go to IDLE with no load_valid_l3.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 without ack: pulse bus_err_l3, drop mem_req, go to IDLE. No load_valid_l3.
- DONE:
  - stall_l3=0; load_valid_l3=1 only for loads.
  - Never starts a new access this cycle, because the L3 register still holds the finished instruction.
  - Next state is IDLE.
- Byte enables and store data:
  - sb: be = 0001<<addr[1:0]; wdata = {4{rs2[7:0]}}.
  - sh: be = 0011<<{addr[1],1'b0}; wdata = {2{rs2[15:0]}}.
  - sw: be = 1111; wdata = rs2.
  - Loads use the same be pattern with mem_we=0.
- Load extension:
  - lb: sign-extend byte addr[1:0] of rdata.
  - lh: sign-extend half addr[1].
  - lw: rdata unmodified.
- Latency:
  - Ack on the first REQ cycle: 3 cycles (IDLE detect, REQ, DONE), stall_l3 high for 2.
  - Each extra wait cycle adds 1.
- Simultaneous events:
  - clear_l3 in IDLE with an access: no request.
  - mem_ack outside REQ: ignored.
  - More than one ins_* bit high is illegal; priority is lw>lh>lb>sw>sh>sb.

Test Plan:
- lb, addr 0x1003, mem_rdata 0x80FF1234, ack on the first REQ cycle -> mem_addr 0x1000, be 1000, stall 2 cycles, load_valid pulse, load_data 0xFFFFFF80.
- sh, addr 0x2002, rs2 0xDEADBEEF -> mem_we 1, be 1100, wdata 0xBEEFBEEF; no load_valid.
- lw, addr 0x3000, ack after 3 wait cycles -> mem_req held 4 cycles with stable addr; stall high 5 cycles; load_data = rdata.
- lw, addr 0x3002 -> misalign_l3 1, mem_req and stall_l3 stay 0.
- lh issued, clear_l3 in the 2nd REQ cycle, ack on the 4th -> stall until ack, no load_valid, FSM returns to IDLE.
- TIMEOUT=4, no ack -> bus_err pulse in the 4th REQ cycle, mem_req drops. Separately, rstn low mid-REQ -> all outputs 0 asynchronously.
